video_stream_checker: RTL and testbench
=======================================

// Module: video_stream_checker
// PURPOSE
//  Synthesizable, parametrised monitor for the dv/hs/vs video stream used between pipeline stages
//  (rgb2y, gamma, etc.). Measures active pixels per line and active lines per frame, checks them
//  against the configured geometry and checks sync/data-valid overlap. Reports sticky error flags and
//  live counters. Sits passively on any stream tap; never drives the stream.
// PARAMETERS
//  DATA_W    8     bits per colour channel
//  CHANNELS  3     channels per pixel (3 = RGB, 1 = Y)
//  H_ACTIVE  1280  expected dv-high cycles per line
//  V_ACTIVE  720   expected active lines per frame
//  CNT_W     12    counter width; must hold max(H_ACTIVE, V_ACTIVE) + 1
// PORTS
//  clk         in   1                  pixel clock
//  rst         in   1                  synchronous, active-high reset
//  dv_i        in   1                  data valid
//  hs_i        in   1                  hsync, active-high
//  vs_i        in   1                  vsync, active-high
//  data_i      in   CHANNELS*DATA_W    pixel data; ch0 in LSBs
//  clr_i       in   1                  clear sticky err_o
//  err_o       out  5                  sticky errors (see BEHAVIOUR)
//  frame_ok_o  out  1                  1-cycle pulse: a complete frame finished error-free
//  line_end_o  out  1                  1-cycle pulse on every dv falling edge
//  pix_cnt_o   out  CNT_W              dv-high cycles in the current line
//  line_cnt_o  out  CNT_W              completed lines in the current frame
//  frame_cnt_o out  16                 completed frames since reset, wraps at 2^16
// BEHAVIOUR
//  - Reset: all outputs 0, FSM -> SYNC. All outputs registered; 1 cycle after the causing input.
//  - Edges detected against 1-cycle-delayed copies of dv_i/vs_i; delayed copies reset to 0.
//  - FSM: SYNC -> (vs rise) VBLANK -> (dv rise) LINE -> (dv fall) HBLANK -> (dv rise) LINE;
//    any state except SYNC -> (vs rise) VBLANK. No checks and no counting in SYNC
//    (first, partial frame after reset is ignored).
//  - pix_cnt: on dv rise set to 1, +1 each further dv-high cycle, saturating at H_ACTIVE+1.
//    Holds its value while dv low; cleared on vs rise.
//  - line_cnt: +1 on each dv fall in LINE, saturating at V_ACTIVE+1; cleared on vs rise.
//  - err_o bits, each set on its event, held until clr_i:
//    [0] SHORT_LINE  dv fall with pix_cnt < H_ACTIVE
//    [1] LONG_LINE   dv high while pix_cnt == H_ACTIVE (flag once per line)
//    [2] FRAME_LEN   vs rise (not from SYNC) with line_cnt != V_ACTIVE
//    [3] SYNC_OVLP   dv_i high in the same cycle as hs_i or vs_i (outside SYNC)
//    [4] DV_IN_VBLK  dv rise while vs_i still high
//  - clr_i and a new error event in the same cycle: the new error bit ends up set; others clear.
//  - frame_ok_o: on vs rise (not from SYNC) pulses iff no error event occurred since the
//    previous vs rise (per-frame shadow flag, independent of clr_i); frame_cnt_o +1 on the same
//    vs rise regardless of errors.
//  - dv fall and vs rise in the same cycle: line counted and checked first, then frame check
//    uses the incremented line_cnt.
//  - Reset mid-frame: everything returns to SYNC; no error raised for the truncated frame.
//  - data_i only used by the optional feature.
// CONFIGURATION
//  VSC_DATA_CRC_EN defined: extra output crc_o [15:0] = CRC-16-CCITT (poly 0x1021, init 0xFFFF)
//  over data_i on every dv-high cycle of a frame, byte ch0 first; latched on vs rise, reset 0.
//  Running CRC re-inits on vs rise. Without the macro: no crc_o port, no CRC logic, data_i unused.
// STRUCTURE
//  - Package video_pkg: vsc_state_e enum (SYNC, VBLANK, LINE, HBLANK), error-bit index
//    localparams ERR_SHORT_LINE..ERR_DV_IN_VBLK, VSC_ERR_W = 5, CRC16 poly/init constants.
//  - One sub-module, vsc_crc16 (per-cycle byte-serial-unrolled CRC), instantiated only under
//    VSC_DATA_CRC_EN.
// TESTING
//  - H_ACTIVE=8, V_ACTIVE=4: reset, 3 clean frames of 4x8 -> frame_ok_o pulses after frames 2,3
//    (frame 1 consumed by SYNC), err_o=0, frame_cnt_o=2, line_end_o 4 pulses/frame.
//  - Line 2 with 7 dv cycles -> err_o[0]=1 one cycle after dv fall; next vs rise no frame_ok_o.
//  - Line with 10 dv cycles -> err_o[1]=1 on 9th dv cycle + 1; pix_cnt_o saturates at 9.
//  - Frame of 5 lines -> err_o[2]=1 after vs rise; clr_i same cycle as a SYNC_OVLP -> err_o=5'b01000.
//  - dv_i and hs_i high together mid-line -> err_o[3]; dv rise while vs_i high -> err_o[4].
//  - rst asserted mid-line, then 2 clean frames -> no errors, first frame_ok_o after 2nd frame.
//  - VSC_DATA_CRC_EN, 1-pixel frame 8'h31,8'h32,8'h33 (CHANNELS=3) ... data "123456789"
//    over 3 pixels -> crc_o = 16'h29B1.

Source files
------------

// File: rtl/video_pkg.sv
// Shared types and constants for the dv/hs/vs stream checker.
package video_pkg;

    typedef enum logic [1:0] {
        SYNC,
        VBLANK,
        LINE,
        HBLANK
    } vsc_state_e;

    localparam int unsigned VSC_ERR_W      = 5;
    localparam int unsigned ERR_SHORT_LINE = 0;
    localparam int unsigned ERR_LONG_LINE  = 1;
    localparam int unsigned ERR_FRAME_LEN  = 2;
    localparam int unsigned ERR_SYNC_OVLP  = 3;
    localparam int unsigned ERR_DV_IN_VBLK = 4;

    localparam logic [15:0] CRC16_POLY = 16'h1021;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

endpackage

// File: rtl/vsc_crc16.sv
// One-cycle CRC-16-CCITT update over a whole pixel, channel 0 first, each channel MSB first.
module vsc_crc16
    import video_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned CHANNELS = 3
) (
    input  logic [15:0]                crc_i,
    input  logic [CHANNELS*DATA_W-1:0] data_i,
    output logic [15:0]                crc_o
);

    always_comb begin
        logic [15:0] c;
        logic        fb;
        c  = crc_i;
        fb = 1'b0;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            for (int b = DATA_W - 1; b >= 0; b--) begin
                fb = c[15] ^ data_i[ch*DATA_W+b];
                c  = {c[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
            end
        end
        crc_o = c;
    end

endmodule

// File: rtl/video_stream_checker.sv
// Passive geometry / sync monitor for the dv/hs/vs pixel stream.
// Optional data CRC output crc_o enabled by defining VSC_DATA_CRC_EN.
module video_stream_checker
    import video_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned CHANNELS = 3,
    parameter int unsigned H_ACTIVE = 1280,
    parameter int unsigned V_ACTIVE = 720,
    parameter int unsigned CNT_W    = 12
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       dv_i,
    input  logic                       hs_i,
    input  logic                       vs_i,
    input  logic [CHANNELS*DATA_W-1:0] data_i,
    input  logic                       clr_i,
    output logic [VSC_ERR_W-1:0]       err_o,
    output logic                       frame_ok_o,
    output logic                       line_end_o,
    output logic [CNT_W-1:0]           pix_cnt_o,
    output logic [CNT_W-1:0]           line_cnt_o,
`ifdef VSC_DATA_CRC_EN
    output logic [15:0]                frame_cnt_o,
    output logic [15:0]                crc_o
`else
    output logic [15:0]                frame_cnt_o
`endif
);

    localparam logic [CNT_W-1:0] H_TGT = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] H_MAX = CNT_W'(H_ACTIVE + 1);
    localparam logic [CNT_W-1:0] V_TGT = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] V_MAX = CNT_W'(V_ACTIVE + 1);

    vsc_state_e           state_q;
    logic                 dv_q, vs_q;
    logic [CNT_W-1:0]     pix_cnt_q, pix_cnt_d;
    logic [CNT_W-1:0]     line_cnt_q, line_cnt_d, line_inc;
    logic [VSC_ERR_W-1:0] err_q, ev;
    logic                 frame_err_q;
    logic                 frame_ok_q, line_end_q;
    logic [15:0]          frame_cnt_q;
    logic                 dv_rise, dv_fall, vs_rise, active;

    assign dv_rise = dv_i & ~dv_q;
    assign dv_fall = ~dv_i & dv_q;
    assign vs_rise = vs_i & ~vs_q;
    assign active  = (state_q != SYNC);

    always_comb begin
        ev       = '0;
        line_inc = line_cnt_q;
        // A line closing on the same cycle as vs rise is counted before the frame check.
        if (active && state_q == LINE && dv_fall && line_cnt_q != V_MAX) begin
            line_inc = line_cnt_q + CNT_W'(1);
        end
        if (active) begin
            ev[ERR_SHORT_LINE] = dv_fall && (pix_cnt_q < H_TGT);
            ev[ERR_LONG_LINE]  = dv_i && dv_q && (pix_cnt_q == H_TGT);
            ev[ERR_FRAME_LEN]  = vs_rise && (line_inc != V_TGT);
            ev[ERR_SYNC_OVLP]  = dv_i && (hs_i || vs_i);
            ev[ERR_DV_IN_VBLK] = dv_rise && vs_i;
        end
    end

    always_comb begin
        pix_cnt_d  = pix_cnt_q;
        line_cnt_d = line_inc;
        if (active) begin
            if (dv_rise) begin
                pix_cnt_d = CNT_W'(1);
            end else if (vs_rise) begin
                pix_cnt_d = '0;
            end else if (dv_i && pix_cnt_q != H_MAX) begin
                pix_cnt_d = pix_cnt_q + CNT_W'(1);
            end
            if (vs_rise) begin
                line_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= SYNC;
            dv_q        <= 1'b0;
            vs_q        <= 1'b0;
            pix_cnt_q   <= '0;
            line_cnt_q  <= '0;
            err_q       <= '0;
            frame_err_q <= 1'b0;
            frame_ok_q  <= 1'b0;
            line_end_q  <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            dv_q        <= dv_i;
            vs_q        <= vs_i;
            pix_cnt_q   <= pix_cnt_d;
            line_cnt_q  <= line_cnt_d;
            err_q       <= clr_i ? ev : (err_q | ev);
            line_end_q  <= dv_fall;
            frame_ok_q  <= active && vs_rise && !frame_err_q && (ev == '0);
            // Shadow error flag tracks one frame and ignores clr_i.
            frame_err_q <= vs_rise ? 1'b0 : (frame_err_q | (|ev));
            if (active && vs_rise) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
            if (vs_rise) begin
                state_q <= VBLANK;
            end else begin
                case (state_q)
                    VBLANK, HBLANK: if (dv_rise) state_q <= LINE;
                    LINE:           if (dv_fall) state_q <= HBLANK;
                    default:        ;
                endcase
            end
        end
    end

    assign err_o       = err_q;
    assign frame_ok_o  = frame_ok_q;
    assign line_end_o  = line_end_q;
    assign pix_cnt_o   = pix_cnt_q;
    assign line_cnt_o  = line_cnt_q;
    assign frame_cnt_o = frame_cnt_q;

`ifdef VSC_DATA_CRC_EN
    logic [15:0] crc_run_q, crc_nxt, crc_q;

    vsc_crc16 #(
        .DATA_W   (DATA_W),
        .CHANNELS (CHANNELS)
    ) u_crc16 (
        .crc_i  (crc_run_q),
        .data_i (data_i),
        .crc_o  (crc_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            crc_run_q <= CRC16_INIT;
            crc_q     <= '0;
        end else if (vs_rise) begin
            crc_q     <= crc_run_q;
            crc_run_q <= CRC16_INIT;
        end else if (dv_i) begin
            crc_run_q <= crc_nxt;
        end
    end

    assign crc_o = crc_q;
`else
    logic unused_data;
    assign unused_data = ^data_i;
`endif

endmodule

// File: tb/tb_video_stream_checker.sv
// Randomised frame stimulus for video_stream_checker checked against an event-level model.
module tb_video_stream_checker;

    localparam int unsigned H  = 8;
    localparam int unsigned V  = 4;
    localparam int unsigned DW = 8;
    localparam int unsigned CH = 3;
    localparam int unsigned CW = 12;

    logic            clk = 1'b0;
    logic            rst, dv, hs, vs, clr;
    logic [CH*DW-1:0] data;
    logic [4:0]      err_o;
    logic            frame_ok_o, line_end_o;
    logic [CW-1:0]   pix_cnt_o, line_cnt_o;
    logic [15:0]     frame_cnt_o;
`ifdef VSC_DATA_CRC_EN
    logic [15:0]     crc_o;
`endif

    always #5 clk = ~clk;

    video_stream_checker #(
        .DATA_W   (DW),
        .CHANNELS (CH),
        .H_ACTIVE (H),
        .V_ACTIVE (V),
        .CNT_W    (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .dv_i        (dv),
        .hs_i        (hs),
        .vs_i        (vs),
        .data_i      (data),
        .clr_i       (clr),
        .err_o       (err_o),
        .frame_ok_o  (frame_ok_o),
        .line_end_o  (line_end_o),
        .pix_cnt_o   (pix_cnt_o),
        .line_cnt_o  (line_cnt_o),
`ifdef VSC_DATA_CRC_EN
        .frame_cnt_o (frame_cnt_o),
        .crc_o       (crc_o)
`else
        .frame_cnt_o (frame_cnt_o)
`endif
    );

    int checks = 0;
    int errors = 0;
    int ok_cnt = 0;
    int le_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: unbounded run/line lengths, clamped only when compared.
    bit         m_synced, m_pdv, m_pvs, m_dirty, m_ok, m_le;
    int         m_run, m_lines, m_frames;
    logic [4:0] m_err;

    function automatic int clampi(input int x, input int m);
        return (x > m) ? m : x;
    endfunction

    task automatic model(input bit r, input bit d, input bit h, input bit v, input bit c);
        logic [4:0] ev;
        bit rd, fd, rv;
        if (r) begin
            m_synced = 0; m_pdv = 0; m_pvs = 0; m_dirty = 0; m_ok = 0; m_le = 0;
            m_run = 0; m_lines = 0; m_frames = 0; m_err = '0;
            return;
        end
        rd   = d && !m_pdv;
        fd   = !d && m_pdv;
        rv   = v && !m_pvs;
        ev   = '0;
        m_ok = 0;
        m_le = fd;
        if (m_synced) begin
            if (rd) m_run = 1;
            else if (d) m_run++;
            if (d && !rd && m_run == H + 1) ev[1] = 1'b1;
            if (fd) begin
                if (m_run < H) ev[0] = 1'b1;
                m_lines++;
            end
            if (d && (h || v)) ev[3] = 1'b1;
            if (rd && v) ev[4] = 1'b1;
            if (rv) begin
                if (m_lines != V) ev[2] = 1'b1;
                m_ok    = !(m_dirty || ev != 0);
                m_frames++;
                m_dirty = 0;
                m_lines = 0;
                m_run   = 0;
            end else begin
                m_dirty = m_dirty || (ev != 0);
            end
        end else if (rv) begin
            m_synced = 1; m_lines = 0; m_run = 0; m_dirty = 0;
        end
        m_err = c ? ev : (m_err | ev);
        m_pdv = d;
        m_pvs = v;
    endtask

    task automatic step(input bit d, input bit h, input bit v, input bit c, input bit r,
                        input logic [CH*DW-1:0] px);
        dv = d; hs = h; vs = v; clr = c; rst = r; data = px;
        @(posedge clk);
        model(r, d, h, v, c);
        #1;
        if (frame_ok_o) ok_cnt++;
        if (line_end_o) le_cnt++;
        check("err", 32'(err_o), 32'(m_err));
        check("frame_ok", 32'(frame_ok_o), 32'(m_ok));
        check("line_end", 32'(line_end_o), 32'(m_le));
        check("pix_cnt", 32'(pix_cnt_o), 32'(clampi(m_run, H + 1)));
        check("line_cnt", 32'(line_cnt_o), 32'(clampi(m_lines, V + 1)));
        check("frame_cnt", 32'(frame_cnt_o), 32'(m_frames & 16'hFFFF));
    endtask

    function automatic bit rclr(input bit rnd);
        return rnd && ($urandom_range(0, 29) == 0);
    endfunction

    // One frame: vblank (vs pulse), nl lines of hblank + active, then tail idle cycles.
    task automatic frame(input int nl, input int mod_ln, input int mod_len, input int ov_ln,
                         input int ov_px, input bit ov_clr, input bit dvv, input int tail,
                         input bit rnd);
        int vb, len, hb;
        bit ov;
        vb = 3 + (rnd ? int'($urandom_range(0, 2)) : 0);
        for (int i = 0; i < vb; i++) step(0, 0, dvv || (i < 2), rclr(rnd), 0, $urandom);
        for (int l = 0; l < nl; l++) begin
            len = (l == mod_ln) ? mod_len : H;
            if (rnd && $urandom_range(0, 4) == 0) len = $urandom_range(H - 2, H + 3);
            hb = rnd ? int'($urandom_range(2, 4)) : 2;
            for (int i = 0; i < hb; i++) step(0, i == 0, dvv && l == 0, rclr(rnd), 0, $urandom);
            for (int p = 0; p < len; p++) begin
                ov = (l == ov_ln) && (p == ov_px);
                step(1, ov, dvv && l == 0 && p == 0, (ov && ov_clr) || rclr(rnd), 0, $urandom);
            end
        end
        for (int i = 0; i < tail; i++) step(0, 0, 0, rclr(rnd), 0, $urandom);
    endtask

    initial begin
        dv = 0; hs = 0; vs = 0; clr = 0; rst = 1; data = '0;
        step(0, 0, 0, 0, 1, '0);
        step(0, 0, 0, 0, 1, '0);

        // Three clean frames: first one only synchronises.
        ok_cnt = 0; le_cnt = 0;
        for (int f = 0; f < 3; f++) frame(V, -1, H, -1, 0, 0, 0, 1, 0);
        check("clean_ok_pulses", 32'(ok_cnt), 32'd2);
        check("clean_frames", 32'(frame_cnt_o), 32'd2);
        check("clean_err", 32'(err_o), 32'd0);
        check("clean_line_ends", 32'(le_cnt), 32'd12);

        frame(V, 1, H - 1, -1, 0, 0, 0, 0, 0);   // short line 2
        frame(V, 2, H + 2, -1, 0, 0, 0, 0, 0);   // long line
        frame(V + 1, -1, H, -1, 0, 0, 0, 0, 0);  // five lines
        frame(V, -1, H, 0, 3, 1, 0, 0, 0);       // overlap with clear
        check("clr_ovlp_err", 32'(err_o), 32'h08);
        frame(V, -1, H, -1, 0, 1, 1, 0, 0);      // dv rises while vs high

        // Reset in the middle of a line, then clean frames.
        frame(2, -1, H, -1, 0, 0, 0, 0, 0);
        for (int p = 0; p < 3; p++) step(1, 0, 0, 0, 0, $urandom);
        step(1, 0, 0, 0, 1, $urandom);
        step(0, 0, 0, 0, 1, $urandom);
        ok_cnt = 0;
        for (int f = 0; f < 3; f++) frame(V, -1, H, -1, 0, 0, 0, 0, 0);
        check("post_rst_err", 32'(err_o), 32'd0);
        check("post_rst_ok", 32'(ok_cnt), 32'd2);

        for (int f = 0; f < 50; f++) begin
            frame(($urandom_range(0, 5) == 0) ? int'($urandom_range(3, 5)) : V, -1, H,
                  ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 2)) : -1,
                  $urandom_range(1, 6), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 9) == 0), $urandom_range(0, 1), 1);
        end

`ifdef VSC_DATA_CRC_EN
        step(0, 0, 0, 0, 1, '0);
        step(0, 0, 1, 0, 0, '0);
        step(0, 0, 0, 0, 0, '0);
        step(0, 0, 1, 0, 0, '0);
        step(0, 0, 0, 0, 0, '0);
        step(1, 0, 0, 0, 0, 24'h333231);
        step(1, 0, 0, 0, 0, 24'h363534);
        step(1, 0, 0, 0, 0, 24'h393837);
        step(0, 0, 1, 0, 0, '0);
        check("crc", 32'(crc_o), 32'h29B1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
